spi_slave: RTL

- SPI responder for the peripheral bus. It is the far end of the existing SPI master links, so the FPGA can be clocked by an external SPI master or another board's master.
- Runs in SPI mode 0 (CPOL=0, CPHA=0), MSB first, 8-bit frames.
- Oversamples asynchronous SCLK/MOSI/CS_N on raw_clk, buffers received bytes in a small FIFO, and exposes a UART-like strobe/busy/ready/clear CPU interface.

---
 rtl/spi_slave_if.sv | 30 +++
 rtl/spi_slave.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_if.sv
// spi_slave_if: SPI pins plus the CPU-side strobe/busy/ready/clear bus for spi_slave.
//   slave  modport: the responder's view (SPI pins in, MISO out, CPU controls in, status out).
//   master modport: the external SPI master / CPU view (the mirror image).
interface spi_slave_if;
  logic       spi_sclk;
  logic       spi_mosi;
  logic       spi_cs_n;
  logic       spi_miso;
  logic       spi_miso_oe;
  logic [7:0] tx_data;
  logic       tx_strobe;
  logic       tx_busy;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       rx_ready_clear;
  logic       overrun;
  logic       underrun;
  logic       status_clear;
  logic       active;

  modport slave (
    input  spi_sclk, spi_mosi, spi_cs_n, tx_data, tx_strobe, rx_ready_clear, status_clear,
    output spi_miso, spi_miso_oe, tx_busy, rx_data, rx_ready, overrun, underrun, active
  );

  modport master (
    output spi_sclk, spi_mosi, spi_cs_n, tx_data, tx_strobe, rx_ready_clear, status_clear,
    input  spi_miso, spi_miso_oe, tx_busy, rx_data, rx_ready, overrun, underrun, active
  );
endinterface

// File: rtl/spi_slave.sv
// spi_slave: mode-0, MSB-first, 8-bit SPI responder oversampled on raw_clk.
//   raw_clk - system clock (posedge)
//   reset   - synchronous, active-high
//   io_bus  - spi_slave_if.slave: SPI pins, TX holding register strobe/busy,
//             RX FIFO head/ready/clear, sticky overrun/underrun with clear, active.
module spi_slave #(
  parameter int unsigned RX_DEPTH_LOG2 = 2,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic        raw_clk,
  input  logic        reset,
  spi_slave_if.slave  io_bus
);

  localparam int unsigned DEPTH = 1 << RX_DEPTH_LOG2;
  localparam int unsigned PTR_W = RX_DEPTH_LOG2;
  localparam int unsigned CNT_W = RX_DEPTH_LOG2 + 1;

  // Input synchronizers, history flops and post-reset settle tracking
  logic [SYNC_STAGES-1:0] r_sclk_sync, r_mosi_sync, r_cs_sync;
  logic                   r_sclk_hist, r_cs_hist;
  logic [SYNC_STAGES:0]   r_settle;
  logic                   r_armed;

  // Frame / shift state
  logic       r_frame;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_rx_shift, r_tx_shift;
  logic [7:0] r_hold;
  logic       r_tx_busy;
  logic       r_overrun, r_underrun;

  // RX FIFO
  logic [7:0]       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [7:0]       r_rx_data;
  logic             r_rx_ready;

  logic w_sclk, w_mosi, w_cs;
  logic w_sclk_rise, w_sclk_fall, w_cs_rise, w_cs_fall;
  logic w_byte_done, w_load, w_under_set;
  logic w_empty, w_full, w_pop, w_push_ok, w_over_set;
  logic [7:0]       w_push_data, w_head_next;
  logic [PTR_W-1:0] w_rd_next;
  logic [CNT_W-1:0] w_count_next;

  assign w_sclk = r_sclk_sync[SYNC_STAGES-1];
  assign w_mosi = r_mosi_sync[SYNC_STAGES-1];
  assign w_cs   = r_cs_sync[SYNC_STAGES-1];

  assign w_sclk_rise = w_sclk & ~r_sclk_hist;
  assign w_sclk_fall = ~w_sclk & r_sclk_hist;
  assign w_cs_rise   = w_cs & ~r_cs_hist;
  // A frame only starts once CS_N has been seen high after reset
  assign w_cs_fall   = ~w_cs & r_cs_hist & r_armed;

  assign w_byte_done = r_frame & ~w_cs_rise & w_sclk_rise & (r_bit_cnt == 3'd7);
  assign w_load      = w_cs_fall | w_byte_done;
  assign w_under_set = w_load & ~r_tx_busy & ~io_bus.tx_strobe;

  assign w_push_data = {r_rx_shift[6:0], w_mosi};
  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == CNT_W'(DEPTH));
  assign w_pop       = io_bus.rx_ready_clear & ~w_empty;
  assign w_push_ok   = w_byte_done & (~w_full | w_pop);
  assign w_over_set  = w_byte_done & w_full & ~w_pop;
  assign w_rd_next   = w_pop ? PTR_W'(r_rd_ptr + 1'b1) : r_rd_ptr;

  // Next head: the byte being pushed if it lands in the slot that becomes the head
  assign w_head_next = (w_push_ok && (r_wr_ptr == w_rd_next)) ? w_push_data : r_mem[w_rd_next];

  always_comb begin
    w_count_next = r_count;
    if (w_push_ok && !w_pop)      w_count_next = r_count + CNT_W'(1);
    else if (!w_push_ok && w_pop) w_count_next = r_count - CNT_W'(1);
  end

  // Synchronizers; idle values on reset so no edge is seen from reset release alone
  always_ff @(posedge raw_clk) begin
    if (reset) begin
      r_sclk_sync <= '0;
      r_mosi_sync <= '0;
      r_cs_sync   <= '1;
      r_sclk_hist <= 1'b0;
      r_cs_hist   <= 1'b1;
      r_settle    <= '0;
      r_armed     <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], io_bus.spi_sclk};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], io_bus.spi_mosi};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], io_bus.spi_cs_n};
      r_sclk_hist <= w_sclk;
      r_cs_hist   <= w_cs;
      r_settle    <= {r_settle[SYNC_STAGES-1:0], 1'b1};
      if (r_settle[SYNC_STAGES] && w_cs) r_armed <= 1'b1;
    end
  end

  // Frame tracking, bit counter and receive shifter
  always_ff @(posedge raw_clk) begin
    if (reset) begin
      r_frame    <= 1'b0;
      r_bit_cnt  <= 3'd0;
      r_rx_shift <= 8'h00;
    end else if (w_cs_rise) begin
      r_frame    <= 1'b0;
      r_bit_cnt  <= 3'd0;
      r_rx_shift <= 8'h00;
    end else if (w_cs_fall) begin
      r_frame    <= 1'b1;
      r_bit_cnt  <= 3'd0;
      r_rx_shift <= 8'h00;
    end else if (r_frame && w_sclk_rise) begin
      r_rx_shift <= w_push_data;
      r_bit_cnt  <= 3'(r_bit_cnt + 3'd1);
    end
  end

  // Holding register and transmit shifter; tx_shift is zero outside a frame
  always_ff @(posedge raw_clk) begin
    if (reset) begin
      r_hold     <= 8'h00;
      r_tx_busy  <= 1'b0;
      r_tx_shift <= 8'h00;
    end else if (w_load) begin
      if (r_tx_busy) begin
        r_tx_shift <= r_hold;
        if (io_bus.tx_strobe) r_hold    <= io_bus.tx_data;
        else                  r_tx_busy <= 1'b0;
      end else if (io_bus.tx_strobe) begin
        r_tx_shift <= io_bus.tx_data;
      end else begin
        r_tx_shift <= 8'h00;
      end
    end else begin
      if (io_bus.tx_strobe && !r_tx_busy) begin
        r_hold    <= io_bus.tx_data;
        r_tx_busy <= 1'b1;
      end
      if (w_cs_rise)
        r_tx_shift <= 8'h00;
      else if (r_frame && w_sclk_fall && (r_bit_cnt != 3'd0))
        r_tx_shift <= {r_tx_shift[6:0], 1'b0};
    end
  end

  // RX FIFO with registered head
  always_ff @(posedge raw_clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= 8'h00;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_rx_data  <= 8'h00;
      r_rx_ready <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= w_push_data;
        r_wr_ptr        <= PTR_W'(r_wr_ptr + 1'b1);
      end
      r_rd_ptr   <= w_rd_next;
      r_count    <= w_count_next;
      r_rx_data  <= w_head_next;
      r_rx_ready <= (w_count_next != '0);
    end
  end

  // Sticky flags: a same-cycle set wins over status_clear
  always_ff @(posedge raw_clk) begin
    if (reset) begin
      r_overrun  <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_overrun  <= w_over_set  | (r_overrun  & ~io_bus.status_clear);
      r_underrun <= w_under_set | (r_underrun & ~io_bus.status_clear);
    end
  end

  assign io_bus.spi_miso    = r_tx_shift[7];
  assign io_bus.spi_miso_oe = r_frame;
  assign io_bus.active      = r_frame;
  assign io_bus.tx_busy     = r_tx_busy;
  assign io_bus.rx_data     = r_rx_data;
  assign io_bus.rx_ready    = r_rx_ready;
  assign io_bus.overrun     = r_overrun;
  assign io_bus.underrun    = r_underrun;

endmodule
